// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone command initiator.
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } wbm_state_t;

    typedef struct packed {
        logic                   we;
        logic [WB_ADDR_W-1:0]   adr;
        logic [WB_DATA_W-1:0]   dat;
        logic [WB_DATA_W/8-1:0] sel;
    } wb_cmd_t;

    typedef struct packed {
        logic [WB_DATA_W-1:0] dat;
        logic                 err;
    } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts cycles without ack and flags the last allowed one.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at TIMEOUT so it never wraps back into the valid window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CAP)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one single read/write cycle.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i
);

    wbm_state_t state_q, state_d;
    logic       accept;
    logic       bus_done;
    logic       expired;

    logic                we_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W/8-1:0] sel_q;
    logic [DATA_W-1:0]   rsp_dat_q;
    logic                rsp_err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is only looked at in BUS, so a late ack from a timed-out slave is harmless.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        bus_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i || expired) begin
                    bus_done = 1'b1;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (accept),
        .enable  ((state_q == BUS) && !wbm_ack_i),
        .expired (expired)
    );

    // Bus-side fields keep their last value between cycles; cyc qualifies them.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (accept) begin
            we_q  <= cmd_we_i;
            adr_q <= cmd_adr_i;
            dat_q <= cmd_dat_i;
            sel_q <= cmd_sel_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else if (bus_done) begin
            rsp_err_q <= !wbm_ack_i;
            rsp_dat_q <= (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign wbm_cyc_o   = (state_q == BUS);
    assign wbm_stb_o   = (state_q == BUS);
    assign rsp_valid_o = (state_q == RSP);
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed plus randomized bench for wb_cmd_master with a behavioural Wishbone slave.
module tb_wb_cmd_master;
    import wb_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [31:0] wbm_adr, wbm_dat_o;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // slave model state
    int          slv_wait = -1;
    logic [31:0] slv_data = '0;
    logic        late_ack = 1'b0;
    int          bus_n = 0;
    int          pulses = 0;
    int          pulse_len = 0;
    logic        unstable = 1'b0;
    logic        cap_we;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;

    wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack)
    );

    always #5 clk = ~clk;

    // Slave acks on its (slv_wait+1)-th strobe cycle; returns junk data when not acking.
    always @(negedge clk) begin
        if (wbm_cyc && wbm_stb) begin
            if (bus_n == 0) begin
                pulses    = pulses + 1;
                pulse_len = 1;
                unstable  = 1'b0;
                cap_we    = wbm_we;
                cap_adr   = wbm_adr;
                cap_dat   = wbm_dat_o;
                cap_sel   = wbm_sel;
            end else begin
                pulse_len = pulse_len + 1;
                if (cap_we !== wbm_we || cap_adr !== wbm_adr || cap_dat !== wbm_dat_o || cap_sel !== wbm_sel)
                    unstable = 1'b1;
            end
            wbm_ack = (bus_n == slv_wait);
            bus_n   = bus_n + 1;
        end else begin
            bus_n   = 0;
            wbm_ack = late_ack;
        end
        wbm_dat_i = wbm_ack ? slv_data : $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int wt, input int hold, input logic late);
        logic [31:0] rd;
        wb_rsp_t     exp_rsp;
        int          exp_len;
        int          lat;
        int          p0;
        rd = $urandom;
        // Reference: ack within the first T strobe cycles wins, otherwise a timeout after T cycles.
        if (wt >= 0 && wt < T) begin
            exp_len     = wt + 1;
            exp_rsp.err = 1'b0;
            exp_rsp.dat = we ? 32'h0 : rd;
        end else begin
            exp_len     = T;
            exp_rsp.err = 1'b1;
            exp_rsp.dat = 32'h0;
        end
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        slv_wait  = wt;
        slv_data  = rd;
        p0        = pulses;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
        chk("cmd_ready_busy", cmd_ready, 0);
        lat = 0;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_latency", lat, exp_len);
        chk("cyc_len", pulse_len, exp_len);
        chk("cyc_pulses", pulses - p0, 1);
        chk("wb_we", cap_we, we);
        chk("wb_adr", cap_adr, adr);
        chk("wb_dat", cap_dat, dat);
        chk("wb_sel", cap_sel, sel);
        chk("wb_stable", unstable, 0);
        chk("rsp_err", rsp_err, exp_rsp.err);
        chk("rsp_dat", rsp_dat, exp_rsp.dat);
        if (late) late_ack = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_dat", rsp_dat, exp_rsp.dat);
            chk("hold_err", rsp_err, exp_rsp.err);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_cyc", wbm_cyc, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        late_ack  = 1'b0;
        chk("rsp_done_valid", rsp_valid, 0);
        chk("rsp_done_ready", cmd_ready, 1);
        chk("rsp_done_pulses", pulses - p0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cyc", wbm_cyc, 0);
        chk("rst_stb", wbm_stb, 0);
        chk("rst_we", wbm_we, 0);
        chk("rst_adr", wbm_adr, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_sel", wbm_sel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;

        do_txn(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 0, 0, 1'b0);
        slv_data = 32'hDEAD_BEEF;
        do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 0, 1'b0);
        do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 3, 1'b1);
        do_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, T - 1, 0, 1'b0);
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'h1, T, 0, 1'b0);
        do_txn(1'b1, 32'h3000_0014, 32'h1234_5678, 4'hC, 1, 5, 1'b0);

        // reset in the middle of a bus cycle
        @(negedge clk);
        slv_wait  = -1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0020;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_cyc", wbm_cyc, 1);
        rst = 1'b1;
        #1;
        chk("midrst_cyc", wbm_cyc, 0);
        chk("midrst_stb", wbm_stb, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_cmd_ready", cmd_ready, 1);
        chk("postrst_cyc", wbm_cyc, 0);
        chk("postrst_rsp_valid", rsp_valid, 0);
        do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int wt;
            wt = $urandom_range(0, T + 2);
            if (wt == T + 2) wt = -1;
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), wt,
                   $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
